// File: rtl/inverse_halftone_filter.sv
`default_nettype none
// ============================================================================
// Module   : inverse_halftone_filter
// Purpose  : Rebuilds a Y8 stream from a dithered Y4/Y1 stream with a causal
//            2-row x 3-column weighted smoothing window. One line-buffer BRAM
//            holds the previous line as raw dithered words.
// Revision : 1.0 - initial release
// ============================================================================
module inverse_halftone_filter #(
  parameter int INPUT_BITS  = 4,
  parameter int OUTPUT_BITS = 8,
  parameter int PIXEL_RATE  = 4,
  parameter int LB_ABITS    = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUT_BITS*PIXEL_RATE-1:0]  in,
  input  logic                              in_valid,
  input  logic                              hsync,
  input  logic                              vsync,
  output logic [OUTPUT_BITS*PIXEL_RATE-1:0] out,
  output logic                              out_valid
);

  localparam int WW    = INPUT_BITS * PIXEL_RATE;
  localparam int ACC_W = 13;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t              state;
  logic [LB_ABITS-1:0] word_cnt;
  logic                first_line;
  logic                first_col;   // pending word is word 0 of its line

  // Pending word and its left neighbours on both rows
  logic [WW-1:0]       cur_c, cur_l, up_c, up_l;

  // Line buffer
  logic [WW-1:0]       lb_mem [2**LB_ABITS];
  logic [WW-1:0]       lb_rd;
  logic [LB_ABITS-1:0] lb_raddr;
  logic                lb_wen;

  logic                sync_pulse, accept, complete;

  // Stage 1: captured window words
  logic                s1_valid, s1_first, s1_last;
  logic [WW-1:0]       s1_c, s1_l, s1_r, s1_uc, s1_ul, s1_ur;

  // Stage 2: per-lane results
  logic                   s2_valid;
  logic [OUTPUT_BITS-1:0] s2_pix [PIXEL_RATE];

  // Window arithmetic
  logic [7:0]       crow [PIXEL_RATE+2];
  logic [7:0]       urow [PIXEL_RATE+2];
  logic [ACC_W-1:0] acc  [PIXEL_RATE];
  logic             unused_acc_bits;

  // Expand one dithered pixel to 8 bits: Y4 p*17 == {p,p}, Y1 replicates the bit
  function automatic logic [7:0] expand(input logic [INPUT_BITS-1:0] p);
    return {(8 / INPUT_BITS){p}};
  endfunction

  // Extract lane j of a word; lane 0 sits in the most significant bits
  function automatic logic [INPUT_BITS-1:0] lane(input logic [WW-1:0] w, input int j);
    return w[(PIXEL_RATE - 1 - j) * INPUT_BITS +: INPUT_BITS];
  endfunction

  // hsync/vsync override in_valid; while ACTIVE every cycle either accepts the
  // next word or ends the line, so each ACTIVE cycle completes the pending word
  assign sync_pulse = hsync | vsync;
  assign accept     = in_valid & ~sync_pulse;
  assign complete   = (state == ACTIVE);

  // Read word n+1 of the previous line when word n arrives so it is available
  // before word n+1 overwrites it; idle cycles prefetch address 0 for the next line
  assign lb_raddr = accept ? word_cnt + 1'b1 : '0;
  assign lb_wen   = accept & ~rst;

  // Line-buffer BRAM: raw word n of the current line is stored at address n
  always_ff @(posedge clk) begin
    if (lb_wen) begin
      lb_mem[word_cnt] <= in;
    end
    lb_rd <= lb_mem[lb_raddr];
  end

  // Control FSM: pending-word state, word counter and first-line flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      first_line <= 1'b1;
      first_col  <= 1'b1;
    end else begin
      if (accept) begin
        state     <= ACTIVE;
        word_cnt  <= word_cnt + 1'b1;
        first_col <= (state == IDLE);
      end else begin
        if (state == ACTIVE) begin
          state      <= IDLE;
          first_line <= 1'b0;
        end
        if (sync_pulse || state == ACTIVE) begin
          word_cnt <= '0;
        end
      end
      if (vsync) begin
        first_line <= 1'b1;
      end
    end
  end

  // Slide the current-row and previous-row windows on every accepted word
  always_ff @(posedge clk) begin
    if (accept) begin
      cur_l <= cur_c;
      cur_c <= in;
      up_l  <= up_c;
      up_c  <= lb_rd;
    end
  end

  // Stage 1: latch the full window of the completing word; on the first line
  // the previous row mirrors the current row
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= complete;
    end
    if (complete) begin
      s1_c     <= cur_c;
      s1_l     <= cur_l;
      s1_r     <= in;
      s1_first <= first_col;
      s1_last  <= ~accept;
      if (first_line) begin
        s1_uc <= cur_c;
        s1_ul <= cur_l;
        s1_ur <= in;
      end else begin
        s1_uc <= up_c;
        s1_ul <= up_l;
        s1_ur <= lb_rd;
      end
    end
  end

  // Expand both rows with edge replication and form the weighted sums
  always_comb begin
    for (int j = 0; j < PIXEL_RATE + 2; j++) begin
      crow[j] = 8'd0;
      urow[j] = 8'd0;
    end
    for (int j = 0; j < PIXEL_RATE; j++) begin
      crow[j+1] = expand(lane(s1_c, j));
      urow[j+1] = expand(lane(s1_uc, j));
    end
    crow[0]            = s1_first ? crow[1] : expand(lane(s1_l, PIXEL_RATE - 1));
    urow[0]            = s1_first ? urow[1] : expand(lane(s1_ul, PIXEL_RATE - 1));
    crow[PIXEL_RATE+1] = s1_last ? crow[PIXEL_RATE] : expand(lane(s1_r, 0));
    urow[PIXEL_RATE+1] = s1_last ? urow[PIXEL_RATE] : expand(lane(s1_ur, 0));
    for (int j = 0; j < PIXEL_RATE; j++) begin
      acc[j] = (ACC_W'(crow[j+1]) << 3)
             + (ACC_W'(crow[j])   << 1)
             + (ACC_W'(crow[j+2]) << 1)
             + (ACC_W'(urow[j+1]) << 1)
             +  ACC_W'(urow[j])
             +  ACC_W'(urow[j+2])
             +  ACC_W'(8);
    end
  end

  // The sum peaks at 4088, so bit 12 and the rounded-off nibble are never needed
  always_comb begin
    unused_acc_bits = 1'b0;
    for (int j = 0; j < PIXEL_RATE; j++) begin
      unused_acc_bits = unused_acc_bits ^ acc[j][ACC_W-1] ^ (^acc[j][3:0]);
    end
  end

  // Stage 2: register the divided-by-16 lane results
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
    end
    for (int j = 0; j < PIXEL_RATE; j++) begin
      s2_pix[j] <= acc[j][11:4];
    end
  end

  // Output register: pack lanes back into a word, lane 0 in the top bits
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        for (int j = 0; j < PIXEL_RATE; j++) begin
          out[(PIXEL_RATE - 1 - j) * OUTPUT_BITS +: OUTPUT_BITS] <= s2_pix[j];
        end
      end
    end
  end

endmodule
`default_nettype wire
